// File: rtl/taus_pkg.sv
// rtl/taus_pkg.sv - taus88 constants, seed limits and control-state enum shared by the generator.
package taus_pkg;

  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  localparam int S0_A = 13;
  localparam int S0_B = 19;
  localparam int S0_C = 12;
  localparam int S1_A = 2;
  localparam int S1_B = 25;
  localparam int S1_C = 4;
  localparam int S2_A = 3;
  localparam int S2_B = 11;
  localparam int S2_C = 17;

  localparam logic [31:0] SEED0_MIN = 32'd2;
  localparam logic [31:0] SEED1_MIN = 32'd8;
  localparam logic [31:0] SEED2_MIN = 32'd16;

  typedef enum logic [1:0] {GEN_A, GEN_B, HOLD} state_e;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;

  // A seed below its minimum would lock that component at zero.
  function automatic logic [31:0] legal_seed(input logic [31:0] seed,
                                             input logic [31:0] min_val,
                                             input logic [31:0] dflt);
    return (seed < min_val) ? dflt : seed;
  endfunction

endpackage

// File: rtl/taus_step.sv
// rtl/taus_step.sv - combinational taus88 step: next component state and output word.
module taus_step
  import taus_pkg::*;
(
  input  taus_state_t cur_i,
  output taus_state_t nxt_o,
  output logic [31:0] word_o
);

  logic [31:0] b0, b1, b2;

  assign b0 = ((cur_i.s0 << S0_A) ^ cur_i.s0) >> S0_B;
  assign b1 = ((cur_i.s1 << S1_A) ^ cur_i.s1) >> S1_B;
  assign b2 = ((cur_i.s2 << S2_A) ^ cur_i.s2) >> S2_B;

  assign nxt_o.s0 = ((cur_i.s0 & MASK0) << S0_C) ^ b0;
  assign nxt_o.s1 = ((cur_i.s1 & MASK1) << S1_C) ^ b1;
  assign nxt_o.s2 = ((cur_i.s2 & MASK2) << S2_C) ^ b2;

  assign word_o = nxt_o.s0 ^ nxt_o.s1 ^ nxt_o.s2;

endmodule

// File: rtl/taus_urng.sv
// rtl/taus_urng.sv - taus88 uniform source packing two words into (u0, u1) over valid/ready; TAUS_SEED_LOAD_EN adds runtime seed loading.
module taus_urng
  import taus_pkg::*;
#(
  parameter logic [31:0] SEED0 = 32'd12345,
  parameter logic [31:0] SEED1 = 32'd67890,
  parameter logic [31:0] SEED2 = 32'd13579
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TAUS_SEED_LOAD_EN
  input  logic        seed_load,
  input  logic [31:0] seed0,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
`endif
  input  logic        out_ready,
  output logic        out_valid,
  output logic [47:0] u0,
  output logic [15:0] u1
);

  state_e      state_q, state_d;
  taus_state_t gen_q, gen_d, gen_nxt;
  logic [31:0] word;
  logic [31:0] word_a_q, word_a_d;
  logic [47:0] u0_q, u0_d;
  logic [15:0] u1_q, u1_d;
  logic        valid_q, valid_d;

  taus_step u_step (
    .cur_i  (gen_q),
    .nxt_o  (gen_nxt),
    .word_o (word)
  );

  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    word_a_d = word_a_q;
    u0_d     = u0_q;
    u1_d     = u1_q;
    valid_d  = valid_q;

    case (state_q)
      GEN_A: begin
        gen_d    = gen_nxt;
        word_a_d = word;
        state_d  = GEN_B;
      end
      GEN_B: begin
        gen_d   = gen_nxt;
        u0_d    = {word_a_q, word[31:16]};
        u1_d    = word[15:0];
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // Accepting the pair also produces the first word of the next one.
        if (out_ready) begin
          gen_d    = gen_nxt;
          word_a_d = word;
          valid_d  = 1'b0;
          state_d  = GEN_B;
        end
      end
      default: state_d = GEN_A;
    endcase

`ifdef TAUS_SEED_LOAD_EN
    if (seed_load) begin
      gen_d.s0 = legal_seed(seed0, SEED0_MIN, SEED0);
      gen_d.s1 = legal_seed(seed1, SEED1_MIN, SEED1);
      gen_d.s2 = legal_seed(seed2, SEED2_MIN, SEED2);
      state_d  = GEN_A;
      valid_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= GEN_A;
      gen_q    <= '{s0: SEED0, s1: SEED1, s2: SEED2};
      word_a_q <= 32'd0;
      u0_q     <= 48'd0;
      u1_q     <= 16'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      word_a_q <= word_a_d;
      u0_q     <= u0_d;
      u1_q     <= u1_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign u0        = u0_q;
  assign u1        = u1_q;

endmodule

// File: doc/taus_urng.md
Name: taus_urng

Overview:
- Uniform random number source feeding the Box-Muller stage with its u0 (48-bit) and u1 (16-bit) operands.
- Three-component Tausworthe generator (taus88) produces one 32-bit word per advance.
- Two consecutive words are packed into one (u0, u1) pair, delivered over a valid/ready handshake.
- This replaces the file-driven stimulus currently used to feed the Box-Muller stage.

Parameters:
- SEED0, 32'd12345, reset seed for component s0; must be > 1.
- SEED1, 32'd67890, reset seed for component s1; must be > 7.
- SEED2, 32'd13579, reset seed for component s2; must be > 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- out_ready  in  1  consumer accepts the pair this cycle.
- out_valid  out  1  u0/u1 hold a valid pair.
- u0  out  48  uniform operand 0 = {word_a[31:0], word_b[31:16]}.
- u1  out  16  uniform operand 1 = word_b[15:0].
- seed_load  in  1  (TAUS_SEED_LOAD_EN only) load seeds this cycle.
- seed0, seed1, seed2  in  32 each  (TAUS_SEED_LOAD_EN only) seed values.

Behaviour:
- Step function, all widths 32-bit, logical shifts, one step per advance:
  - b = ((s0<<13)^s0)>>19; s0' = ((s0 & 32'hFFFFFFFE)<<12) ^ b.
  - b = ((s1<<2)^s1)>>25; s1' = ((s1 & 32'hFFFFFFF8)<<4) ^ b.
  - b = ((s2<<3)^s2)>>11; s2' = ((s2 & 32'hFFFFFFF0)<<17) ^ b.
  - word = s0' ^ s1' ^ s2'.
- Reset (reset low, asynchronous):
  - s0/s1/s2 = SEED0/1/2.
  - state = GEN_A.
  - out_valid = 0, u0 = 48'd0, u1 = 16'd0, word_a register = 0.
- FSM states:
  - GEN_A: advance; word_a <= word; go to GEN_B.
  - GEN_B: advance; u0 <= {word_a, word[31:16]}; u1 <= word[15:0]; out_valid <= 1; go to HOLD.
  - HOLD: generator frozen; u0/u1 stable while out_valid=1 and out_ready=0.
    - On out_ready=1: accept the pair.
    - Same cycle: advance and capture word_a; go to GEN_B.
    - out_valid stays 1 through GEN_B only if a new pair lands that edge; otherwise out_valid <= 0 on the accept edge.
- Throughput and latency:
  - First valid pair: 2 clock edges after reset deassertion.
  - Sustained throughput: 1 pair per 2 cycles with out_ready held high.
  - out_valid toggles 0/1 under constant ready: asserted 1 cycle, deasserted 1 cycle.
- Handshake rules:
  - Transfer occurs on any rising edge with out_valid & out_ready.
  - out_ready while out_valid=0 has no effect.
  - out_valid never drops without a transfer.
- Sequence is deterministic per seed: the k-th pair equals the golden model's words 2k and 2k+1.
- Reset asserted mid-operation (any state, including HOLD with a pending pair):
  - Pending pair is discarded.
  - Sequence restarts from the seeds.

Optional Feature:
- Macro: TAUS_SEED_LOAD_EN.
- Defined: seed_load and seed0/1/2 ports exist.
  - seed_load=1 on an edge: s0/s1/s2 <= seeds, state <= GEN_A, out_valid <= 0 (pending pair dropped).
  - Illegal seeds are replaced by the parameter default: seed0 < 2, seed1 < 8, seed2 < 16.
  - seed_load has priority over a simultaneous transfer.
- Undefined: ports absent; seeds come only from parameters at reset.

Decomposition:
- Package taus_pkg holds:
  - mask constants MASK0/1/2 = FFFFFFFE/FFFFFFF8/FFFFFFF0;
  - shift constants (13,19,12), (2,25,4), (3,11,17);
  - seed minimums 2/8/16;
  - state enum {GEN_A, GEN_B, HOLD}.
- Sub-module taus_step: purely combinational next-state and word for one step, instantiated once.

Test Plan:
- Reset, then out_ready=1 for 20000 cycles:
  - out_valid first rises at edge 2.
  - 10000 pairs match golden taus88 (seeds 12345/67890/13579), packed as specified.
  - Dump to file for Box-Muller stage cross-check.
- Backpressure: out_ready=0 for 50 cycles after the first valid:
  - u0/u1/out_valid remain constant.
  - After ready=1, the next pair equals golden pair 1 (no skip, no repeat).
- Random out_ready (50%) over 5000 cycles:
  - Accepted-pair sequence is identical to the ready=1 run.
  - out_valid never falls without a transfer.
- Reset pulsed low while in HOLD:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the first pair again equals golden pair 0.
- TAUS_SEED_LOAD_EN with seed_load, seeds 0/3/15:
  - Generator uses 12345/67890/13579.
  - Next pair equals golden pair 0.
  - A seed_load coincident with a transfer yields out_valid=0 on the next cycle.
- TAUS_SEED_LOAD_EN with seed_load, seeds 100/200/300:
  - Pairs match golden taus88 from those seeds.
